// File: rtl/bram_stream_writer.sv
// Receives 144-bit pixel beats over AXI-Stream and writes nine 16-bit direction lanes to the BRAM bank.
// Define BRAM_WR_TLAST_CHECK_EN to honour tlast and report framing errors; otherwise frames are fixed-length.
module bram_stream_writer #(
   parameter int DATA_WIDTH    = 16,
   parameter int DEPTH         = 2500,
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                       s00_axis_aclk,
   input  logic                       s00_axis_areset,
   input  logic [9*DATA_WIDTH-1:0]    s00_axis_tdata,
   input  logic [(9*DATA_WIDTH)/8-1:0] s00_axis_tstrb,
   input  logic                       s00_axis_tvalid,
   input  logic                       s00_axis_tlast,
   output logic                       s00_axis_tready,
   input  logic                       frame_consumed,
   output logic                       write_en,
   output logic [ADDRESS_WIDTH-1:0]   write_addr,
   output logic [DATA_WIDTH-1:0]      n_out,
   output logic [DATA_WIDTH-1:0]      null_out,
   output logic [DATA_WIDTH-1:0]      ne_out,
   output logic [DATA_WIDTH-1:0]      e_out,
   output logic [DATA_WIDTH-1:0]      se_out,
   output logic [DATA_WIDTH-1:0]      s_out,
   output logic [DATA_WIDTH-1:0]      sw_out,
   output logic [DATA_WIDTH-1:0]      w_out,
   output logic [DATA_WIDTH-1:0]      nw_out,
   output logic                       frame_done,
   output logic                       frame_error
);

   localparam int LANES = 9;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [ADDRESS_WIDTH-1:0]   r_cnt;
   logic [ADDRESS_WIDTH-1:0]   w_cnt_next;
   logic                       r_tready;
   logic                       w_tready_next;
   logic                       r_write_en;
   logic [ADDRESS_WIDTH-1:0]   r_write_addr;
   logic                       r_frame_done;
   logic                       w_done_next;
   logic                       r_frame_error;
   logic                       w_err_next;

   logic                       w_hs;
   logic                       w_last_addr;
   logic                       w_tlast;
   logic                       w_frame_err;
   logic                       w_frame_end;
   logic                       w_unused;
   logic [DATA_WIDTH-1:0]      w_lane [LANES];

   // tready mirrors the registered state, so a handshake can only happen in RECV
   assign w_hs        = s00_axis_tvalid & r_tready;
   assign w_last_addr = (r_cnt == LAST_ADDR);

`ifdef BRAM_WR_TLAST_CHECK_EN
   assign w_tlast     = s00_axis_tlast;
   assign w_frame_err = w_last_addr ^ w_tlast;
`else
   assign w_tlast     = 1'b0;
   assign w_frame_err = 1'b0;
`endif

   assign w_frame_end = w_hs & (w_last_addr | w_tlast);
   assign w_unused    = ^{s00_axis_tstrb, s00_axis_tlast};

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_err_next   = r_frame_error;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_RECV;
            w_cnt_next   = '0;
         end
         ST_RECV: begin
            if (w_hs) begin
               if (w_frame_end) begin
                  w_state_next = ST_FLUSH;
                  w_cnt_next   = '0;
                  if (w_frame_err) begin
                     w_err_next = 1'b1;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (frame_consumed) begin
               w_state_next = ST_RECV;
               w_cnt_next   = '0;
               w_err_next   = 1'b0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      w_tready_next = (w_state_next == ST_RECV);
      w_done_next   = (w_state_next == ST_DONE);
   end

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_cnt         <= '0;
         r_tready      <= 1'b0;
         r_write_en    <= 1'b0;
         r_write_addr  <= '0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_next;
         r_tready      <= w_tready_next;
         r_write_en    <= w_hs;
         r_frame_done  <= w_done_next;
         r_frame_error <= w_err_next;
         if (w_hs) begin
            r_write_addr <= r_cnt;
         end
      end
   end

   // Lane gi holds tdata[gi*DATA_WIDTH +: DATA_WIDTH]; lane 0 is nw, lane 8 is n
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] r_lane;
         always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
            if (s00_axis_areset) begin
               r_lane <= '0;
            end else if (w_hs) begin
               r_lane <= s00_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         assign w_lane[gi] = r_lane;
      end
   endgenerate

   assign s00_axis_tready = r_tready;
   assign write_en        = r_write_en;
   assign write_addr      = r_write_addr;
   assign frame_done      = r_frame_done;
   assign frame_error     = r_frame_error;
   assign n_out           = w_lane[8];
   assign null_out        = w_lane[7];
   assign ne_out          = w_lane[6];
   assign e_out           = w_lane[5];
   assign se_out          = w_lane[4];
   assign s_out           = w_lane[3];
   assign sw_out          = w_lane[2];
   assign w_out           = w_lane[1];
   assign nw_out          = w_lane[0];

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer: full, gapped, short/unterminated (or spurious-tlast) and reset-interrupted frames.
// Beat i carries lane k = k*4096 + i so lane ordering and addressing are both visible.
module tb_bram_stream_writer;

   localparam int DEPTH = 2500;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [143:0]  tdata = '0;
   logic [17:0]   tstrb = '1;
   logic          tvalid = 1'b0;
   logic          tlast = 1'b0;
   logic          tready;
   logic          consumed = 1'b0;
   logic          wen;
   logic [11:0]   waddr;
   logic [15:0]   n_o, null_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o;
   logic          done;
   logic          err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_stream_writer #(.DATA_WIDTH(16), .DEPTH(DEPTH), .ADDRESS_WIDTH(12)) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tdata  (tdata),
      .s00_axis_tstrb  (tstrb),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tlast  (tlast),
      .s00_axis_tready (tready),
      .frame_consumed  (consumed),
      .write_en        (wen),
      .write_addr      (waddr),
      .n_out           (n_o),
      .null_out        (null_o),
      .ne_out          (ne_o),
      .e_out           (e_o),
      .se_out          (se_o),
      .s_out           (s_o),
      .sw_out          (sw_o),
      .w_out           (w_o),
      .nw_out          (nw_o),
      .frame_done      (done),
      .frame_error     (err)
   );

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [143:0] beat_word(input int i);
      logic [143:0] w;
      for (int k = 0; k < 9; k++) begin
         w[k*16 +: 16] = 16'(k*4096 + i);
      end
      return w;
   endfunction

   // Monitor: samples 2 time units after each falling edge, records BRAM writes.
   logic [143:0] mem [DEPTH];
   int           mon_wr = 0;
   int           mon_seq_err = 0;
   int           mon_hs_err = 0;
   int           clr_gen = 0;
   wire [143:0]  lanes = {n_o, null_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o};

   initial begin
      logic         hs_prev;
      logic [143:0] d_prev;
      int           seen_gen;
      hs_prev  = 1'b0;
      d_prev   = '0;
      seen_gen = 0;
      forever begin
         @(negedge clk);
         #2;
         if (seen_gen != clr_gen) begin
            seen_gen    = clr_gen;
            mon_wr      = 0;
            mon_seq_err = 0;
            mon_hs_err  = 0;
            for (int a = 0; a < DEPTH; a++) mem[a] = '0;
         end
         if (rst) begin
            hs_prev = 1'b0;
         end else begin
            if (wen !== hs_prev) mon_hs_err++;
            if (wen === 1'b1) begin
               if (lanes !== d_prev) mon_hs_err++;
               if (int'(waddr) != mon_wr) mon_seq_err++;
               if (int'(waddr) < DEPTH) mem[waddr] = lanes;
               mon_wr++;
            end
            hs_prev = tvalid && tready;
            d_prev  = tdata;
         end
      end
   end

   function automatic int mem_bad(input int n);
      int cnt = 0;
      for (int a = 0; a < n; a++) begin
         if (mem[a] !== beat_word(a)) cnt++;
      end
      return cnt;
   endfunction

   // Called just after a falling edge; returns just after the falling edge following acceptance.
   task automatic drive_beat(input int v, input bit last, output bit ok);
      logic rdy;
      ok     = 1'b0;
      tdata  = beat_word(v);
      tvalid = 1'b1;
      tlast  = last;
      for (int t = 0; t < 16 && !ok; t++) begin
         rdy = tready;
         @(negedge clk);
         ok = rdy;
      end
   endtask

   task automatic send_frame(input int first, input int n, input int tlast_at, input int gap);
      bit ok;
      for (int i = first; i < n; i++) begin
         while ($urandom_range(0, 99) < gap) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            @(negedge clk);
         end
         drive_beat(i, i == tlast_at, ok);
         if (!ok) begin
            chk("beat_accept", 0, 1);
            break;
         end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic end_of_frame(input string tag, input logic exp_err);
      chk({tag, "_flush_tready"}, tready, 0);
      chk({tag, "_flush_wen"}, wen, 1);
      chk({tag, "_flush_done"}, done, 0);
      @(negedge clk);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_done_tready"}, tready, 0);
      #3;
   endtask

   task automatic check_writes(input string tag, input int n);
      chk({tag, "_writes"}, mon_wr, n);
      chk({tag, "_addr_seq"}, mon_seq_err, 0);
      chk({tag, "_wen_vs_hs"}, mon_hs_err, 0);
      chk({tag, "_mem"}, mem_bad(n), 0);
      $display("frame %s: writes=%0d total=%0d bad=%0d", tag, mon_wr, total, bad);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      consumed = 1'b1;
      @(negedge clk);
      consumed = 1'b0;
      chk({tag, "_consume_tready"}, tready, 1);
      chk({tag, "_consume_err"}, err, 0);
      chk({tag, "_consume_done"}, done, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tready", tready, 0);
      chk("rst_wen", wen, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_lanes", lanes, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("start_tready", tready, 1);

      // Gap-free full frame
      clr_gen++;
      send_frame(0, DEPTH, DEPTH - 1, 0);
      end_of_frame("full", 1'b0);
      chk("full_n_lane", n_o, 16'h89c3);
      chk("full_nw_lane", nw_o, 16'h09c3);
      check_writes("full", DEPTH);
      consume("full");

      // Same frame with ~30% idle cycles
      clr_gen++;
      send_frame(0, DEPTH, DEPTH - 1, 30);
      end_of_frame("gap", 1'b0);
      check_writes("gap", DEPTH);
      consume("gap");

`ifdef BRAM_WR_TLAST_CHECK_EN
      // Short frame: tlast on beat 9
      clr_gen++;
      send_frame(0, 10, 9, 0);
      end_of_frame("short", 1'b1);
      chk("short_n_lane", n_o, 16'h8009);
      chk("short_nw_lane", nw_o, 16'h0009);
      chk("short_waddr", waddr, 9);
      check_writes("short", 10);
      consume("short");

      // Missing tlast: frame still ends at DEPTH beats, next beat held off
      clr_gen++;
      send_frame(0, DEPTH, -1, 0);
      end_of_frame("miss", 1'b1);
      check_writes("miss", DEPTH);
      clr_gen++;
      tdata  = beat_word(0);
      tvalid = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      chk("miss_stall_writes", mon_wr, 0);
      chk("miss_stall_err", err, 1);
      @(negedge clk);
      consumed = 1'b1;
      @(negedge clk);
      consumed = 1'b0;
      chk("miss_consume_tready", tready, 1);
      chk("miss_consume_err", err, 0);
      @(negedge clk);
      tvalid = 1'b0;
      #3;
      chk("miss_next_writes", mon_wr, 1);
      chk("miss_next_waddr", waddr, 0);
`else
      // Spurious tlast on beat 5 must not end the frame
      clr_gen++;
      send_frame(0, 6, 5, 0);
      chk("spur_tready", tready, 1);
      chk("spur_done", done, 0);
      chk("spur_err", err, 0);
      send_frame(6, DEPTH, DEPTH - 1, 0);
      end_of_frame("spur", 1'b0);
      check_writes("spur", DEPTH);
      consume("spur");
`endif

      // Reset while beat 1200 is presented, then a clean frame
      clr_gen++;
      send_frame(0, 1200, -1, 0);
      tdata  = beat_word(1200);
      tvalid = 1'b1;
      rst    = 1'b1;
      #1;
      chk("mid_rst_tready", tready, 0);
      chk("mid_rst_wen", wen, 0);
      chk("mid_rst_waddr", waddr, 0);
      chk("mid_rst_lanes", lanes, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      tvalid = 1'b0;
      rst    = 1'b0;
      clr_gen++;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_tready", tready, 1);
      send_frame(0, DEPTH, DEPTH - 1, 0);
      end_of_frame("post_rst", 1'b0);
      check_writes("post_rst", DEPTH);
      consume("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
